// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 command sequencer.
// Holds the FSM state type, the fixed init tables and the us-to-cycles helper.
package lcd_pkg;

  typedef enum logic [3:0] {
    POWER_WAIT,
    INIT_SEND,
    INIT_WAIT_DONE,
    INIT_DELAY,
    CMD_HI,
    CMD_HI_WAIT,
    CMD_LO,
    CMD_LO_WAIT,
    GAP,
    IDLE
  } seq_state_t;

  localparam int CLEAR_US = 1520;
  localparam int CMD_US   = 37;

  localparam logic [3:0] INIT_NIBBLES [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
  localparam logic [7:0] INIT_BYTES   [5] = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};

  function automatic longint unsigned us_to_cycles(input longint unsigned freq,
                                                   input longint unsigned us);
    return (freq * us) / 64'd1000000;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Init table lookup: indices 0-3 are bare nibbles, 4-8 are full bytes.
// Returns the value and the post-command wait for that step.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int FREQ          = 50000000,
  parameter int INIT_WAIT1_US = 4100,
  parameter int INIT_WAIT2_US = 100
) (
  input  logic [3:0]  idx,
  output logic        is_byte,
  output logic [7:0]  value,
  output logic [20:0] delay_cycles
);

  localparam logic [20:0] WAIT1_CYC = 21'(us_to_cycles(64'(FREQ), 64'(INIT_WAIT1_US)));
  localparam logic [20:0] WAIT2_CYC = 21'(us_to_cycles(64'(FREQ), 64'(INIT_WAIT2_US)));
  localparam logic [20:0] CLEAR_CYC = 21'(us_to_cycles(64'(FREQ), 64'(CLEAR_US)));
  localparam logic [20:0] CMD_CYC   = 21'(us_to_cycles(64'(FREQ), 64'(CMD_US)));

  logic [2:0] byte_off;
  assign byte_off = 3'(idx - 4'd4);

  always_comb begin
    is_byte      = 1'b0;
    value        = 8'h00;
    delay_cycles = '0;
    if (idx < 4'd4) begin
      value        = {4'h0, INIT_NIBBLES[idx[1:0]]};
      delay_cycles = (idx == 4'd0) ? WAIT1_CYC : WAIT2_CYC;
    end else if (idx <= 4'd8) begin
      is_byte      = 1'b1;
      value        = INIT_BYTES[byte_off];
      delay_cycles = (value == 8'h01 || value == 8'h02) ? CLEAR_CYC : CMD_CYC;
    end
  end

endmodule

// File: rtl/lcd_command_sequencer.sv
// Drives the 4-bit HD44780 nibble engine: power-up wait, fixed init sequence,
// then application bytes sent as high/low nibble pairs.
module lcd_command_sequencer
  import lcd_pkg::*;
#(
  parameter int FREQ          = 50000000,
  parameter int POWERUP_US    = 40000,
  parameter int INIT_WAIT1_US = 4100,
  parameter int INIT_WAIT2_US = 100
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  input  logic [7:0]  req_byte,
  input  logic        req_rs,
  output logic        req_ready,
  output logic        init_done,
  output logic        xfer_send,
  output logic [3:0]  xfer_nibble,
  output logic        xfer_rs,
  output logic [20:0] xfer_delay,
  output logic        xfer_read_busy,
  output logic        xfer_mode4bit,
  input  logic        xfer_done,
  output seq_state_t  dbg_state
);

  localparam longint unsigned TIMER_LIMIT = 64'd1 << 21;
  localparam longint unsigned POWER_L = us_to_cycles(64'(FREQ), 64'(POWERUP_US));
  localparam longint unsigned WAIT1_L = us_to_cycles(64'(FREQ), 64'(INIT_WAIT1_US));
  localparam longint unsigned WAIT2_L = us_to_cycles(64'(FREQ), 64'(INIT_WAIT2_US));
  localparam longint unsigned CLEAR_L = us_to_cycles(64'(FREQ), 64'(CLEAR_US));
  localparam logic [20:0] POWER_CYC = 21'(POWER_L);
  localparam logic [20:0] CLEAR_CYC = 21'(CLEAR_L);
  localparam logic [20:0] CMD_CYC   = 21'(us_to_cycles(64'(FREQ), 64'(CMD_US)));

  if (POWER_L >= TIMER_LIMIT || WAIT1_L >= TIMER_LIMIT ||
      WAIT2_L >= TIMER_LIMIT || CLEAR_L >= TIMER_LIMIT) begin : g_delay_range
    $error("lcd_command_sequencer: a delay count does not fit the 21-bit timer");
  end

  function automatic logic [20:0] byte_delay(input logic [7:0] b);
    return (b == 8'h01 || b == 8'h02) ? CLEAR_CYC : CMD_CYC;
  endfunction

  seq_state_t  state, state_next;
  logic [20:0] timer, timer_next;
  logic [3:0]  idx, idx_next;
  logic [7:0]  cur_byte, cur_byte_next;
  logic        cur_rs, cur_rs_next;
  logic        gap_to_lo, gap_to_lo_next;
  logic        send_d, rs_d, rb_d, ready_d, done_d;
  logic [3:0]  nib_d;
  logic [20:0] dly_d;
  logic        rom_is_byte;
  logic [7:0]  rom_value;
  logic [20:0] rom_delay;
  logic        power_hit, delay_hit, accept;

  // Handshake: a request transfers on a cycle where req_valid && req_ready are
  // both high; req_ready is registered, is high only while idle after init, and
  // drops the cycle after a transfer, so req_byte/req_rs are ignored otherwise.
  assign accept    = (state == IDLE) && req_valid && req_ready;
  assign power_hit = ({1'b0, timer} + 22'd1) >= {1'b0, POWER_CYC};
  assign delay_hit = ({1'b0, timer} + 22'd1) >= {1'b0, xfer_delay};

  // The ROM is addressed by the next index so its value is ready for the send.
  always_comb begin
    idx_next = idx;
    if (state == INIT_DELAY && delay_hit)
      idx_next = idx + 4'd1;
    else if (state == GAP && !gap_to_lo && !init_done && idx != 4'd8)
      idx_next = idx + 4'd1;
  end

  lcd_init_rom #(
    .FREQ(FREQ), .INIT_WAIT1_US(INIT_WAIT1_US), .INIT_WAIT2_US(INIT_WAIT2_US)
  ) u_rom (
    .idx(idx_next), .is_byte(rom_is_byte), .value(rom_value), .delay_cycles(rom_delay)
  );

  always_comb begin
    state_next     = state;
    cur_byte_next  = cur_byte;
    cur_rs_next    = cur_rs;
    gap_to_lo_next = gap_to_lo;
    case (state)
      POWER_WAIT:     if (power_hit) state_next = INIT_SEND;
      INIT_SEND:      state_next = INIT_WAIT_DONE;
      INIT_WAIT_DONE: if (xfer_done) state_next = INIT_DELAY;
      INIT_DELAY:     if (delay_hit) state_next = rom_is_byte ? CMD_HI : INIT_SEND;
      CMD_HI:         state_next = CMD_HI_WAIT;
      CMD_HI_WAIT: if (xfer_done) begin
        state_next     = GAP;
        gap_to_lo_next = 1'b1;
      end
      CMD_LO:         state_next = CMD_LO_WAIT;
      CMD_LO_WAIT: if (xfer_done) begin
        state_next     = GAP;
        gap_to_lo_next = 1'b0;
      end
      GAP: begin
        if (gap_to_lo)                        state_next = CMD_LO;
        else if (init_done || idx == 4'd8)    state_next = IDLE;
        else                                  state_next = CMD_HI;
      end
      IDLE:           if (accept) state_next = CMD_HI;
      default:        state_next = POWER_WAIT;
    endcase

    timer_next = (state_next != state) ? '0 : timer + 21'd1;

    if (state_next == CMD_HI) begin
      cur_byte_next = accept ? req_byte : rom_value;
      cur_rs_next   = accept & req_rs;
    end

    // Engine command lines change only on a send and hold until the next one.
    send_d = 1'b0;
    nib_d  = xfer_nibble;
    rs_d   = xfer_rs;
    dly_d  = xfer_delay;
    rb_d   = xfer_read_busy;
    case (state_next)
      INIT_SEND: begin
        send_d = 1'b1;
        nib_d  = rom_value[3:0];
        rs_d   = 1'b0;
        dly_d  = rom_delay;
        rb_d   = 1'b0;
      end
      CMD_HI: begin
        send_d = 1'b1;
        nib_d  = cur_byte_next[7:4];
        rs_d   = cur_rs_next;
        dly_d  = byte_delay(cur_byte_next);
        rb_d   = 1'b0;
      end
      CMD_LO: begin
        send_d = 1'b1;
        nib_d  = cur_byte[3:0];
        rs_d   = cur_rs;
        rb_d   = 1'b1;
      end
      default: ;
    endcase

    ready_d = (state == IDLE) && (state_next == IDLE) && init_done;
    done_d  = init_done || (state_next == IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= POWER_WAIT;
      timer          <= '0;
      idx            <= '0;
      cur_byte       <= '0;
      cur_rs         <= 1'b0;
      gap_to_lo      <= 1'b0;
      req_ready      <= 1'b0;
      init_done      <= 1'b0;
      xfer_send      <= 1'b0;
      xfer_nibble    <= '0;
      xfer_rs        <= 1'b0;
      xfer_delay     <= '0;
      xfer_read_busy <= 1'b0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      idx            <= idx_next;
      cur_byte       <= cur_byte_next;
      cur_rs         <= cur_rs_next;
      gap_to_lo      <= gap_to_lo_next;
      req_ready      <= ready_d;
      init_done      <= done_d;
      xfer_send      <= send_d;
      xfer_nibble    <= nib_d;
      xfer_rs        <= rs_d;
      xfer_delay     <= dly_d;
      xfer_read_busy <= rb_d;
    end
  end

  assign xfer_mode4bit = 1'b1;
  assign dbg_state     = state;

endmodule

// File: doc/lcd_command_sequencer.md
Name: lcd_command_sequencer

Overview:
- Sequences the 4-bit HD44780 nibble transfer engine (lcd_transfer).
- After reset it waits for LCD power-up, then runs the fixed 4-bit init sequence.
- It then accepts byte requests (instruction or data) on a valid/ready handshake and issues each byte as two nibble transfers.
- Sits between the display application logic and the nibble engine. It owns every control input of the engine.

Parameters:
- FREQ, 50000000, clock frequency in Hz.
- POWERUP_US, 40000, wait from reset release to the first nibble, in µs.
- INIT_WAIT1_US, 4100, wait after the first 0x3 init nibble.
- INIT_WAIT2_US, 100, wait after each later init nibble.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  1  byte request valid.
- req_byte  in  8  byte to send.
- req_rs  in  1  0 = instruction, 1 = data (RS line).
- req_ready  out  1  sequencer can accept a request.
- init_done  out  1  init sequence complete; stays high until reset.
- xfer_send  out  1  to engine sendCommand; one-cycle pulse.
- xfer_nibble  out  4  to engine command.
- xfer_rs  out  1  to engine command_rs.
- xfer_delay  out  21  to engine commandDelay; post-command delay in cycles, informational.
- xfer_read_busy  out  1  to engine read_busy.
- xfer_mode4bit  out  1  to engine mode4bit; constant 1.
- xfer_done  in  1  from engine commandDone; one-cycle pulse.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = POWER_WAIT, timer = 0, init index = 0.
  - req_ready = 0, init_done = 0, xfer_send = 0.
  - xfer_nibble = 0, xfer_rs = 0, xfer_delay = 0, xfer_read_busy = 0.
- All outputs are registered.
- States: POWER_WAIT, INIT_SEND, INIT_WAIT_DONE, INIT_DELAY, CMD_HI, CMD_HI_WAIT, CMD_LO, CMD_LO_WAIT, GAP, IDLE.
- POWER_WAIT: count to POWERUP_US*FREQ/1e6 cycles, then go to INIT_SEND. The engine has no reset; this wait covers any transfer it had in flight.
- Init nibble phase (indices 0-3): nibbles 0x3, 0x3, 0x3, 0x2, all RS = 0, xfer_read_busy = 0.
  - INIT_SEND pulses xfer_send, then INIT_WAIT_DONE waits for xfer_done.
  - INIT_DELAY then counts INIT_WAIT1_US after index 0, or INIT_WAIT2_US after indices 1-3.
- Init byte phase (indices 4-8): bytes 0x28, 0x08, 0x01, 0x06, 0x0C, RS = 0, sent through the byte path below.
- init_done rises in the cycle IDLE is first entered.
- Byte path:
  - CMD_HI drives the high nibble with xfer_read_busy = 0 and pulses xfer_send, then CMD_HI_WAIT waits for xfer_done.
  - GAP, then CMD_LO drives the low nibble with xfer_read_busy = 1, so the engine busy-polls after the full byte. CMD_LO_WAIT waits for xfer_done.
  - GAP, then the next init byte, or IDLE.
- Send spacing: the engine returns to idle 2 cycles after xfer_done. xfer_send must not rise earlier than 2 cycles after xfer_done; GAP provides this.
- xfer_rs and xfer_nibble are held stable from the xfer_send cycle until xfer_done.
- xfer_delay = cycles for 1520 µs when the byte is 0x01 or 0x02 (clear/home), otherwise cycles for 37 µs. During the init nibble phase it equals the current INIT_DELAY count.
- Request handshake:
  - req_ready = 1 only in IDLE with init_done = 1.
  - A request is accepted when req_valid && req_ready; req_byte and req_rs are latched and the state goes to CMD_HI.
  - req_ready falls on the following cycle.
  - A held req_valid is accepted again only on the next IDLE.
  - req_byte changes while not ready are ignored.
- xfer_done outside a *_WAIT state is ignored.
- Timer: 21-bit, cleared on every state entry. The elaboration check fails if any delay count is ≥ 2^21.
- Reset mid-operation: all state returns to the reset values immediately; the full power-up wait and init rerun.

Decomposition:
- Package lcd_pkg holds:
  - the seq_state_t enum;
  - the init table constants (INIT_NIBBLES[4], INIT_BYTES[5]);
  - the us_to_cycles constant function;
  - the CLEAR_US = 1520 and CMD_US = 37 constants.
- One sub-module, lcd_init_rom: combinational index (0-8) to {is_byte, value[7:0], delay_cycles[20:0]}.

Test Plan:
- Reset with FREQ = 1000000 → first xfer_send exactly 40000 cycles after RST_N rises; xfer_nibble = 0x3, xfer_rs = 0, xfer_read_busy = 0.
- Engine model returning xfer_done 10 cycles after each send → nibble stream 3,3,3,2,2,8,0,8,0,1,0,6,0,C.
  - Gaps after the 0x3/0x2 nibbles are ≥ 4100/100/100/100 cycles.
  - init_done rises after the final C; req_ready = 1 on the next cycle.
- req_byte = 0x41, req_rs = 1 → nibbles 0x4 (read_busy = 0) then 0x1 (read_busy = 1), both with xfer_rs = 1; req_ready low throughout and high again 3 cycles after the second xfer_done.
- req_valid held high across two bytes 0xA5, 0x5A → exactly two acceptances; nibbles A,5,5,A; xfer_send spacing after every xfer_done is ≥ 2 cycles.
- req_byte = 0x01, req_rs = 0 → xfer_delay = 1520 cycles (at FREQ = 1 MHz) during both nibbles.
- RST_N pulsed low during CMD_LO_WAIT → all outputs go to reset values asynchronously; no xfer_send for 40000 cycles after release; the init sequence restarts at nibble 0x3.
